// File: rtl/mas_radix_pkg.sv
// -----------------------------------------------------------------------------
// mas_radix_pkg
// Shared types for the radix-4 Booth sequential multiplier.
//   booth_op_t    : decoded action for one Booth digit
//   mult_state_t  : control state of the iterative multiplier
//   booth_decode(): maps a 3-bit overlapping multiplier window to its action
// -----------------------------------------------------------------------------
package mas_radix_pkg;

  typedef enum logic [2:0] {
    BOOTH_ZERO,
    BOOTH_P1,
    BOOTH_P2,
    BOOTH_M1,
    BOOTH_M2
  } booth_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mult_state_t;

  // Window is {b[2i+1], b[2i], b[2i-1]}; the digit value is
  // -2*b[2i+1] + b[2i] + b[2i-1].
  function automatic booth_op_t booth_decode(input logic [2:0] digit);
    booth_op_t op;
    case (digit)
      3'b001, 3'b010: op = BOOTH_P1;
      3'b011:         op = BOOTH_P2;
      3'b100:         op = BOOTH_M2;
      3'b101, 3'b110: op = BOOTH_M1;
      default:        op = BOOTH_ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mas_radix4_booth_sel.sv
// -----------------------------------------------------------------------------
// mas_radix4_booth_sel
// Combinational Booth term selector. Produces 0, A or 2A at W+3 bits, already
// bit-inverted when the digit is negative; the caller adds neg_o as carry-in
// to complete the two's-complement negation inside the same addition.
// Ports:
//   digit_i        [2:0]  overlapping multiplier window
//   multiplicand_i [W+1:0] multiplicand, already sign/zero-extended by 2 bits
//   term_o         [W+2:0] selected (possibly inverted) partial term
//   neg_o                  1 when the digit is negative (carry-in of +1)
// -----------------------------------------------------------------------------
module mas_radix4_booth_sel
  import mas_radix_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]   digit_i,
  input  logic [W+1:0] multiplicand_i,
  output logic [W+2:0] term_o,
  output logic         neg_o
);

  booth_op_t    op;
  logic [W+2:0] mag;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    op    = booth_decode(digit_i);
    mag   = '0;
    neg_o = 1'b0;
    case (op)
      BOOTH_P1: mag = {multiplicand_i[W+1], multiplicand_i};
      BOOTH_P2: mag = {multiplicand_i, 1'b0};
      BOOTH_M1: begin
        mag   = {multiplicand_i[W+1], multiplicand_i};
        neg_o = 1'b1;
      end
      BOOTH_M2: begin
        mag   = {multiplicand_i, 1'b0};
        neg_o = 1'b1;
      end
      default: ;
    endcase
    term_o = neg_o ? ~mag : mag;
  end

endmodule

// File: rtl/mas_radix4_seq_mult.sv
// -----------------------------------------------------------------------------
// mas_radix4_seq_mult
// Iterative radix-4 Booth multiplier, one Booth digit retired per clock.
// Operands are extended to WIDTH+2 bits so the same datapath is exact for
// signed and unsigned operation; NDIG = WIDTH/2+1 digits are processed.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      operand handshake (ready only in IDLE)
//   a_i, b_i [WIDTH-1:0]     multiplicand / multiplier
//   signed_i                 1: two's complement operands, 0: unsigned
//   out_valid / out_ready    product handshake (valid only in DONE)
//   prod_o [2*WIDTH-1:0]     registered full-precision product
//   busy_o                   high while computing or holding a result
// -----------------------------------------------------------------------------
module mas_radix4_seq_mult
  import mas_radix_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 signed_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod_o,
  output logic                 busy_o
);

  localparam int NDIG = WIDTH / 2 + 1;
  localparam int CW   = $clog2(NDIG);
  localparam int EW   = WIDTH + 2;   // extended operand width
  localparam int AW   = WIDTH + 4;   // accumulator (upper product) width

  mult_state_t          state_q;
  logic [CW-1:0]        cnt_q;
  logic [EW-1:0]        a_q;
  logic [EW-1:0]        b_q;         // multiplier, shifted right 2 per digit
  logic                 bprev_q;     // b[2i-1] for the current digit
  logic [AW-1:0]        acc_q;       // upper part of the running product
  logic [EW-1:0]        lo_q;        // product bits shifted out of acc_q
  logic [2*WIDTH-1:0]   prod_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 busy_q;

  logic [EW-1:0]        a_ext;
  logic [EW-1:0]        b_ext;
  logic [2:0]           digit;
  logic [EW:0]          term;
  logic                 neg;
  logic [AW-1:0]        sum;
  logic [AW-1:0]        acc_d;
  logic [EW-1:0]        lo_d;
  logic [2*WIDTH-1:0]   prod_d;

  assign a_ext = signed_i ? {{2{a_i[WIDTH-1]}}, a_i} : {2'b00, a_i};
  assign b_ext = signed_i ? {{2{b_i[WIDTH-1]}}, b_i} : {2'b00, b_i};
  assign digit = {b_q[1:0], bprev_q};

  mas_radix4_booth_sel #(
    .W (WIDTH)
  ) u_booth_sel (
    .digit_i        (digit),
    .multiplicand_i (a_q),
    .term_o         (term),
    .neg_o          (neg)
  );

  // One adder: the term enters at the weight of the current digit (the top of
  // the running product), the carry-in finishes the negation, and the sum is
  // shifted right by one digit with its two LSBs moving into lo.
  assign sum   = acc_q + {term[EW], term} + AW'(neg);
  assign acc_d = {{2{sum[AW-1]}}, sum[AW-1:2]};
  assign lo_d  = {sum[1:0], lo_q[EW-1:2]};
  // After the last digit {acc_d, lo_d} is the exact product; keep 2*WIDTH bits.
  assign prod_d = {acc_d[WIDTH-3:0], lo_d};

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  // NOTE: the datapath registers are reset too; they are few and a clean
  // known state after reset costs nothing here (no memory arrays involved).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      bprev_q     <= 1'b0;
      acc_q       <= '0;
      lo_q        <= '0;
      prod_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q        <= a_ext;
            b_q        <= b_ext;
            bprev_q    <= 1'b0;
            acc_q      <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            state_q    <= ST_BUSY;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_BUSY: begin
          acc_q   <= acc_d;
          lo_q    <= lo_d;
          b_q     <= {2'b00, b_q[EW-1:2]};
          bprev_q <= b_q[1];
          if (cnt_q == CW'(NDIG - 1)) begin
            cnt_q       <= '0;
            prod_q      <= prod_d;
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign prod_o    = prod_q;
  assign busy_o    = busy_q;

endmodule
